rsp_s1_prep_ahbic_rr_arb: RTL and testbench
===========================================

// Module: rsp_s1_prep_ahbic_rr_arb
// PURPOSE
//  Output-stage arbiter for a shared AHB slave port of the rsp_s1_prep interconnect.
//  Shares one slave between NUM_PORTS input stages using round-robin priority.
//  Holds the grant for the whole of a locked sequence and for fixed-length bursts.
//  Drives addr_in_port/no_port to the output-stage address and data muxes.
// PARAMETERS
//  NUM_PORTS  4  number of requesting input ports (2..8)
//  PORT_W     2  width of the port index; equals clog2(NUM_PORTS)
// PORTS
//  HCLK          in   1          AHB system clock
//  HRESET        in   1          asynchronous active-high reset
//  req_port      in   NUM_PORTS  per-port request; bit i = input port i wants the slave
//  HREADYM       in   1          slave-side HREADY; transfer/phase completes
//  HSELM         in   1          slave select of the currently muxed address phase
//  HTRANSM       in   2          HTRANS of the muxed address phase
//  HBURSTM       in   3          HBURST of the muxed address phase
//  HMASTLOCKM    in   1          HMASTLOCK of the muxed address phase
//  addr_in_port  out  PORT_W     index of the input port driving the slave address phase
//  no_port       out  1          1 = no port selected; slave sees IDLE
//  grant_hold    out  1          1 = grant frozen by an unfinished fixed burst (debug/perf)
// BEHAVIOUR
//  Reset and update
//  - On reset: addr_in_port=0, no_port=1, grant_hold=0, rem_cnt=0, last_ptr=NUM_PORTS-1.
//    With last_ptr at NUM_PORTS-1, port 0 wins the first arbitration.
//  - Registers update only on posedge HCLK with HREADYM=1.
//  - Decisions are combinational on the current phase; outputs take effect next cycle.
//  Accepted beat
//  - acc = HREADYM & HSELM & ~no_port.
//  Burst counter rem_cnt (4b) = beats still owed after the current beat
//  - acc & NONSEQ: load len-1. len is 4 for HBURSTM 010/011, 8 for 100/101, 16 for 110/111.
//    len is 1 for SINGLE (000) and INCR (001).
//  - acc & SEQ & rem_cnt!=0: decrement.
//  - acc & BUSY: no change.
//  - IDLE, or a NONSEQ that is not a burst start (early termination/ERROR): counter reloads or clears.
//  - rem_nxt denotes the value the counter will hold after this cycle.
//  Arbitration priority, first match wins, evaluated when HREADYM=1
//  1. HMASTLOCKM=1: keep addr_in_port; no_port_nxt=0.
//  2. rem_nxt!=0: keep port (burst hold); grant_hold_nxt=1.
//  3. |req_port: pick the first set req bit, searching (last_ptr+1) mod NUM_PORTS upward
//     with wrap. Set addr_in_port to it, no_port_nxt=0, last_ptr to the winner.
//  4. No request, HSELM=1: keep current port (IDLE park); no_port_nxt=0.
//  5. Otherwise: no_port_nxt=1; addr_in_port unchanged.
//  - grant_hold_nxt is 0 in every case other than 2.
//  - last_ptr changes only in case 3.
//  - A port re-winning in case 3 still moves last_ptr, giving fairness across ports.
//  Boundary conditions
//  - HREADYM=0 (wait state): all state frozen, whatever req/HTRANSM do.
//  - Requests are level signals; a request dropped before a HREADYM=1 cycle is never granted.
//  - A lock asserted in the same cycle as a burst end: lock wins; rem_cnt still updates.
//  - Single-port configuration (req_port=1'b1) degenerates to a fixed grant of port 0.
//  - HRESET asserted mid-burst or mid-lock: immediate return to reset values; no_port=1.
//  - Burst boundaries assume a legal AHB sequence and are not checked.
//  - Wrap-burst address wrap is invisible here; only the beat count matters.
// TESTING
//  1. Reset, then req_port=4'b0101, HREADYM=1 -> port 0 granted first, then port 2,
//     then port 0 (alternation); no_port goes 1->0.
//  2. Port 1 NONSEQ INCR4 (HBURSTM=011) while req_port=4'b1111 -> addr_in_port stays 1
//     for 4 beats with grant_hold=1, then moves to 2.
//  3. INCR8 with HREADYM low for 3 cycles mid-burst -> no decrement or grant change
//     during waits; exactly 8 accepted beats before handover.
//  4. HMASTLOCKM=1 on port 3 for 5 cycles with all requests high -> grant held at 3;
//     released on the first unlocked HREADYM cycle to port 0.
//  5. All req low, HSELM=0 -> no_port=1 next cycle; HSELM=1 with HTRANSM=IDLE -> port parked,
//     no_port=0.
//  6. Assert HRESET in beat 2 of INCR16 -> next edge no_port=1, addr_in_port=0,
//     grant_hold=0; first grant after release goes to port 0.

Source files
------------

// File: rtl/rsp_s1_prep_ahbic_rr_arb.sv
// Round-robin output-stage arbiter for a shared AHB slave port.
// Holds the grant across locked sequences and fixed-length bursts.
module rsp_s1_prep_ahbic_rr_arb #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [NUM_PORTS-1:0] req_port,
  input  logic                 HREADYM,
  input  logic                 HSELM,
  input  logic [1:0]           HTRANSM,
  input  logic [2:0]           HBURSTM,
  input  logic                 HMASTLOCKM,
  output logic [PORT_W-1:0]    addr_in_port,
  output logic                 no_port,
  output logic                 grant_hold
);

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic [PORT_W-1:0] port_q, port_d, last_q, last_d, rr_pick, idx;
  logic              np_q, np_d, gh_q, gh_d;
  logic [3:0]        rem_q, rem_d, rem_nxt, len_m1;
  logic              acc, found;

  always_comb begin
    case (HBURSTM[2:1])
      2'b01:   len_m1 = 4'd3;
      2'b10:   len_m1 = 4'd7;
      2'b11:   len_m1 = 4'd15;
      default: len_m1 = 4'd0;
    endcase
  end

  // Anything other than an accepted beat leaves no burst outstanding.
  always_comb begin
    acc     = HREADYM & HSELM & ~np_q;
    rem_nxt = 4'd0;
    if (acc) begin
      case (HTRANSM)
        T_NONSEQ: rem_nxt = len_m1;
        T_SEQ:    rem_nxt = (rem_q != 4'd0) ? rem_q - 4'd1 : 4'd0;
        T_BUSY:   rem_nxt = rem_q;
        T_IDLE:   rem_nxt = 4'd0;
        default:  rem_nxt = 4'd0;
      endcase
    end
  end

  // Search starts one past the last winner and wraps.
  always_comb begin
    found   = 1'b0;
    rr_pick = port_q;
    idx     = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = PORT_W'((int'(last_q) + i) % NUM_PORTS);
      if (!found && req_port[idx]) begin
        found   = 1'b1;
        rr_pick = idx;
      end
    end
  end

  always_comb begin
    port_d = port_q;
    np_d   = np_q;
    gh_d   = gh_q;
    rem_d  = rem_q;
    last_d = last_q;
    if (HREADYM) begin
      rem_d = rem_nxt;
      gh_d  = 1'b0;
      if (HMASTLOCKM) begin
        np_d = 1'b0;
      end else if (rem_nxt != 4'd0) begin
        gh_d = 1'b1;
      end else if (found) begin
        port_d = rr_pick;
        last_d = rr_pick;
        np_d   = 1'b0;
      end else if (HSELM) begin
        np_d = 1'b0;
      end else begin
        np_d = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      port_q <= '0;
      np_q   <= 1'b1;
      gh_q   <= 1'b0;
      rem_q  <= 4'd0;
      last_q <= PORT_W'(NUM_PORTS - 1);
    end else begin
      port_q <= port_d;
      np_q   <= np_d;
      gh_q   <= gh_d;
      rem_q  <= rem_d;
      last_q <= last_d;
    end
  end

  assign addr_in_port = port_q;
  assign no_port      = np_q;
  assign grant_hold   = gh_q;

endmodule

// File: tb/tb_rsp_s1_prep_ahbic_rr_arb.sv
// Directed bench for the round-robin AHB arbiter; driver queues expected
// outputs, a monitor pops and compares one cycle after each edge.
module tb_rsp_s1_prep_ahbic_rr_arb;

  localparam int NP = 4;
  localparam int PW = 2;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;
  logic [NP-1:0] req_port = '0;
  logic          HREADYM = 1'b0, HSELM = 1'b0, HMASTLOCKM = 1'b0;
  logic [1:0]    HTRANSM = 2'b00;
  logic [2:0]    HBURSTM = 3'b000;
  logic [PW-1:0] addr_in_port;
  logic          no_port, grant_hold;

  localparam logic [1:0] IDLE = 2'b00, NSQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SGL = 3'b000, I4 = 3'b011, I8 = 3'b101, I16 = 3'b111;

  typedef struct {
    int            tag;
    logic [PW-1:0] port;
    logic          np;
    logic          gh;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   tag   = 0;

  rsp_s1_prep_ahbic_rr_arb #(.NUM_PORTS(NP), .PORT_W(PW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .req_port(req_port), .HREADYM(HREADYM),
    .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
    .addr_in_port(addr_in_port), .no_port(no_port), .grant_hold(grant_hold)
  );

  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (addr_in_port !== e.port || no_port !== e.np || grant_hold !== e.gh) begin
        n_bad++;
        $display("FAIL vec%0d: port/no_port/hold got %0d/%b/%b want %0d/%b/%b",
                 e.tag, addr_in_port, no_port, grant_hold, e.port, e.np, e.gh);
      end
    end
  end

  task automatic step(input logic rst, input logic [NP-1:0] rq, input logic rdy,
                      input logic sel, input logic [1:0] tr, input logic [2:0] bu,
                      input logic lk, input int ep, input logic enp, input logic egh);
    exp_t e;
    @(negedge HCLK);
    HRESET = rst; req_port = rq; HREADYM = rdy; HSELM = sel;
    HTRANSM = tr; HBURSTM = bu; HMASTLOCKM = lk;
    e.tag = tag; e.port = PW'(ep); e.np = enp; e.gh = egh;
    exp_q.push_back(e);
    tag++;
  endtask

  initial begin
    // reset state
    step(1, 4'b0000, 0, 0, IDLE, SGL, 0, 0, 1, 0);
    // alternation between ports 0 and 2
    step(0, 4'b0101, 1, 0, IDLE, SGL, 0, 0, 0, 0);
    step(0, 4'b0101, 1, 1, NSQ,  SGL, 0, 2, 0, 0);
    step(0, 4'b0101, 1, 1, NSQ,  SGL, 0, 0, 0, 0);
    step(0, 4'b0101, 1, 1, NSQ,  SGL, 0, 2, 0, 0);
    // INCR4 on port 1 holds the grant, then hands to 2
    step(0, 4'b0010, 1, 1, NSQ,  SGL, 0, 1, 0, 0);
    step(0, 4'b1111, 1, 1, NSQ,  I4,  0, 1, 0, 1);
    step(0, 4'b1111, 1, 1, SEQ,  I4,  0, 1, 0, 1);
    step(0, 4'b1111, 1, 1, SEQ,  I4,  0, 1, 0, 1);
    step(0, 4'b1111, 1, 1, SEQ,  I4,  0, 2, 0, 0);
    // INCR8 on port 2 with three wait states frozen mid-burst
    step(0, 4'b1111, 1, 1, NSQ,  I8,  0, 2, 0, 1);
    step(0, 4'b1111, 1, 1, SEQ,  I8,  0, 2, 0, 1);
    step(0, 4'b0001, 0, 1, NSQ,  SGL, 0, 2, 0, 1);
    step(0, 4'b1000, 0, 0, IDLE, SGL, 0, 2, 0, 1);
    step(0, 4'b1111, 0, 1, SEQ,  I8,  1, 2, 0, 1);
    for (int b = 3; b <= 7; b++)
      step(0, 4'b1111, 1, 1, SEQ, I8, 0, 2, 0, 1);
    step(0, 4'b1111, 1, 1, SEQ,  I8,  0, 3, 0, 0);
    // lock on port 3 for five cycles, released to port 0
    for (int c = 0; c < 5; c++)
      step(0, 4'b1111, 1, 1, NSQ, SGL, 1, 3, 0, 0);
    step(0, 4'b1111, 1, 1, NSQ,  SGL, 0, 0, 0, 0);
    // no request: drop to no_port, then park on HSELM
    step(0, 4'b0100, 1, 1, NSQ,  SGL, 0, 2, 0, 0);
    step(0, 4'b0000, 1, 0, IDLE, SGL, 0, 2, 1, 0);
    step(0, 4'b0000, 1, 1, IDLE, SGL, 0, 2, 0, 0);
    step(0, 4'b0000, 1, 1, IDLE, SGL, 0, 2, 0, 0);
    // reset during INCR16, first grant after release is port 0
    step(0, 4'b1111, 1, 1, NSQ,  I16, 0, 2, 0, 1);
    step(0, 4'b1111, 1, 1, SEQ,  I16, 0, 2, 0, 1);
    step(1, 4'b1111, 1, 1, SEQ,  I16, 0, 0, 1, 0);
    step(0, 4'b1111, 1, 0, IDLE, SGL, 0, 0, 0, 0);
    // lock coinciding with burst end wins over rotation
    step(0, 4'b1111, 1, 1, NSQ,  I4,  0, 0, 0, 1);
    step(0, 4'b1111, 1, 1, SEQ,  I4,  0, 0, 0, 1);
    step(0, 4'b1111, 1, 1, SEQ,  I4,  0, 0, 0, 1);
    step(0, 4'b1111, 1, 1, SEQ,  I4,  1, 0, 0, 0);
    step(0, 4'b1111, 1, 1, NSQ,  SGL, 0, 1, 0, 0);
    // a request seen only during waits is not granted
    step(0, 4'b0100, 0, 1, NSQ,  SGL, 0, 1, 0, 0);
    step(0, 4'b0000, 1, 1, IDLE, SGL, 0, 1, 0, 0);

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge HCLK);
    #2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
